// File: rtl/arb_mux_nto1.sv
// Registered N-to-1 valid/ready mux with fixed-select or round-robin grant.
// Define ARB_MUX_SKID_EN to add a skid entry that registers IN_READY.
module arb_mux_nto1 #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
  input  logic [SEL_W-1:0]          CONTROL,
  input  logic                      MODE,
  output logic [WIDTH-1:0]          OP,
  output logic                      OP_VALID,
  input  logic                      OP_READY,
  output logic [SEL_W-1:0]          OP_CHAN
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] k;
  logic             grant_ok;
  logic             can_load;
  logic             ready_en;
  logic             accept;
  logic [WIDTH-1:0] grant_data;
  int               idx;

`ifdef ARB_MUX_SKID_EN
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_chan;
`endif

  assign can_load = ~OP_VALID | OP_READY;

`ifdef ARB_MUX_SKID_EN
  assign ready_en = ~skid_full;
`else
  assign ready_en = can_load;
`endif

  // Round-robin scans downward so the lowest offset from ptr wins.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    idx      = 0;
    k        = '0;
    if (!MODE) begin
      grant    = CONTROL;
      grant_ok = int'(CONTROL) < CHANNELS;
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        idx = int'(ptr) + i;
        if (idx >= CHANNELS)
          idx = idx - CHANNELS;
        k = SEL_W'(idx);
        if (IN_VALID[k]) begin
          grant    = k;
          grant_ok = 1'b1;
        end
      end
    end
  end

  assign grant_data = IN_DATA[grant*WIDTH +: WIDTH];
  assign accept     = RSTN & grant_ok & ready_en & IN_VALID[grant];
  assign next_ptr   = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    IN_READY = '0;
    if (RSTN && grant_ok)
      IN_READY[grant] = ready_en;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      OP       <= '0;
      OP_VALID <= 1'b0;
      OP_CHAN  <= '0;
      ptr      <= '0;
`ifdef ARB_MUX_SKID_EN
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_chan <= '0;
`endif
    end else begin
`ifdef ARB_MUX_SKID_EN
      if (can_load) begin
        if (skid_full) begin
          OP        <= skid_data;
          OP_CHAN   <= skid_chan;
          OP_VALID  <= 1'b1;
          skid_full <= 1'b0;
        end else begin
          OP_VALID <= accept;
          if (accept) begin
            OP      <= grant_data;
            OP_CHAN <= grant;
          end
        end
      end else if (accept) begin
        skid_data <= grant_data;
        skid_chan <= grant;
        skid_full <= 1'b1;
      end
`else
      if (can_load) begin
        OP_VALID <= accept;
        if (accept) begin
          OP      <= grant_data;
          OP_CHAN <= grant;
        end
      end
`endif
      if (accept && MODE)
        ptr <= next_ptr;
    end
  end

endmodule
